// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller for the IF and MEM request ports. MEM has priority.
// Each transfer is split into little-endian byte accesses, and every output is registered.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_enable_in,
  input  logic [31:0] if_addr_in,
  output logic        if_enable_out,
  output logic [31:0] if_data_out,
  output logic        if_busy_out,
  input  logic        mem_enable_in,
  input  logic        mem_rw_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_data_in,
  input  logic [2:0]  mem_len_in,
  output logic        mem_enable_out,
  output logic [31:0] mem_data_out,
  output logic        mem_busy_out,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        own_mem_q, own_mem_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [23:0] word_q, word_d;

  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_en_q, if_en_d;
  logic [31:0] if_data_q, if_data_d;
  logic        if_busy_q, if_busy_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_busy_q, mem_busy_d;

  logic [2:0]  wr_len;
  logic [2:0]  rd_off;
  logic [7:0]  wr_byte;

  // Lengths other than 0, 1 and 2 are treated as a full word.
  always_comb begin
    case (mem_len_in)
      3'd0:    wr_len = 3'd0;
      3'd1:    wr_len = 3'd1;
      3'd2:    wr_len = 3'd2;
      default: wr_len = 3'd4;
    endcase
  end

  // The last read address is held for one extra cycle while the final byte is captured.
  assign rd_off = (cnt_q == 3'd3) ? 3'd3 : cnt_q + 3'd1;

  always_comb begin
    case (cnt_q)
      3'd0:    wr_byte = data_q[15:8];
      3'd1:    wr_byte = data_q[23:16];
      default: wr_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    own_mem_d  = own_mem_q;
    addr_d     = addr_q;
    data_d     = data_q;
    word_d     = word_q;
    ram_a_d    = '0;
    ram_dout_d = '0;
    ram_wr_d   = 1'b0;
    if_en_d    = 1'b0;
    if_data_d  = '0;
    if_busy_d  = 1'b0;
    mem_en_d   = 1'b0;
    mem_data_d = '0;
    mem_busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        word_d = '0;
        if (mem_enable_in) begin
          own_mem_d = 1'b1;
          addr_d    = mem_addr_in;
          data_d    = mem_data_in;
          n_d       = wr_len;
          if (!mem_rw_in) begin
            state_d    = S_RD;
            ram_a_d    = mem_addr_in;
            mem_busy_d = 1'b1;
          end else if (wr_len == 3'd0) begin
            state_d  = S_DONE;
            mem_en_d = 1'b1;
          end else begin
            state_d    = S_WR;
            ram_a_d    = mem_addr_in;
            ram_dout_d = mem_data_in[7:0];
            ram_wr_d   = 1'b1;
            mem_busy_d = 1'b1;
          end
        end else if (if_enable_in) begin
          own_mem_d = 1'b0;
          addr_d    = if_addr_in;
          state_d   = S_RD;
          ram_a_d   = if_addr_in;
          if_busy_d = 1'b1;
        end
      end
      S_RD: begin
        case (cnt_q)
          3'd1:    word_d[7:0]   = ram_din;
          3'd2:    word_d[15:8]  = ram_din;
          3'd3:    word_d[23:16] = ram_din;
          default: word_d        = word_q;
        endcase
        if (cnt_q == 3'd4) begin
          state_d = S_DONE;
          if (own_mem_q) begin
            mem_en_d   = 1'b1;
            mem_data_d = {ram_din, word_q};
          end else begin
            if_en_d   = 1'b1;
            if_data_d = {ram_din, word_q};
          end
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_a_d    = addr_q + {29'b0, rd_off};
          mem_busy_d = own_mem_q;
          if_busy_d  = !own_mem_q;
        end
      end
      S_WR: begin
        if (cnt_q + 3'd1 < n_q) begin
          cnt_d      = cnt_q + 3'd1;
          ram_a_d    = addr_q + {29'b0, cnt_d};
          ram_dout_d = wr_byte;
          ram_wr_d   = 1'b1;
          mem_busy_d = 1'b1;
        end else begin
          state_d  = S_DONE;
          mem_en_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      own_mem_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      word_q     <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
      if_en_q    <= 1'b0;
      if_data_q  <= '0;
      if_busy_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_data_q <= '0;
      mem_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      own_mem_q  <= own_mem_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      word_q     <= word_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      if_en_q    <= if_en_d;
      if_data_q  <= if_data_d;
      if_busy_q  <= if_busy_d;
      mem_en_q   <= mem_en_d;
      mem_data_q <= mem_data_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  assign ram_a          = ram_a_q;
  assign ram_dout       = ram_dout_q;
  assign ram_wr         = ram_wr_q;
  assign if_enable_out  = if_en_q;
  assign if_data_out    = if_data_q;
  assign if_busy_out    = if_busy_q;
  assign mem_enable_out = mem_en_q;
  assign mem_data_out   = mem_data_q;
  assign mem_busy_out   = mem_busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a transaction-level schedule model compared every cycle,
// plus directed checks against hand-computed literals.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_enable_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic        if_enable_out;
  logic [31:0] if_data_out;
  logic        if_busy_out;
  logic        mem_enable_in = 1'b0;
  logic        mem_rw_in = 1'b0;
  logic [31:0] mem_addr_in = '0;
  logic [31:0] mem_data_in = '0;
  logic [2:0]  mem_len_in = '0;
  logic        mem_enable_out;
  logic [31:0] mem_data_out;
  logic        mem_busy_out;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_enable_in(if_enable_in), .if_addr_in(if_addr_in),
    .if_enable_out(if_enable_out), .if_data_out(if_data_out), .if_busy_out(if_busy_out),
    .mem_enable_in(mem_enable_in), .mem_rw_in(mem_rw_in), .mem_addr_in(mem_addr_in),
    .mem_data_in(mem_data_in), .mem_len_in(mem_len_in),
    .mem_enable_out(mem_enable_out), .mem_data_out(mem_data_out), .mem_busy_out(mem_busy_out),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RAM with one cycle of read latency: the byte for the address seen last cycle.
  logic [7:0]  mem [0:65535];
  logic [15:0] last_a = '0;
  always @(negedge clk) begin
    ram_din = mem[last_a];
    last_a  = ram_a[15:0];
    if (ram_wr) mem[ram_a[15:0]] = ram_dout;
  end

  typedef struct packed {
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic        if_en;
    logic [31:0] if_data;
    logic        if_busy;
    logic        mem_en;
    logic [31:0] mem_data;
    logic        mem_busy;
  } vec_t;

  vec_t sched_q[$];
  vec_t cur = '0;

  // Lists the expected outputs for every cycle of a transaction, starting the cycle after accept.
  task automatic plan(input bit is_mem, input bit rw, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] len);
    vec_t v;
    int   n;
    logic [15:0] b;
    b = a[15:0];
    if (!rw) begin
      for (int k = 0; k < 5; k++) begin
        v = '0;
        v.ram_a = a + ((k > 3) ? 32'd3 : 32'(k));
        if (is_mem) v.mem_busy = 1'b1; else v.if_busy = 1'b1;
        sched_q.push_back(v);
      end
      v = '0;
      if (is_mem) begin
        v.mem_en   = 1'b1;
        v.mem_data = {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
      end else begin
        v.if_en   = 1'b1;
        v.if_data = {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
      end
      sched_q.push_back(v);
    end else begin
      n = (len == 3'd0) ? 0 : (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
        v = '0;
        v.ram_a    = a + 32'(k);
        v.ram_dout = 8'(d >> (8 * k));
        v.ram_wr   = 1'b1;
        v.mem_busy = 1'b1;
        sched_q.push_back(v);
      end
      v = '0;
      v.mem_en = 1'b1;
      sched_q.push_back(v);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sched_q.delete();
      cur = '0;
    end else begin
      if (sched_q.size() == 0 && !cur.if_en && !cur.mem_en) begin
        if (mem_enable_in) plan(1'b1, mem_rw_in, mem_addr_in, mem_data_in, mem_len_in);
        else if (if_enable_in) plan(1'b0, 1'b0, if_addr_in, 32'd0, 3'd0);
      end
      if (sched_q.size() > 0) cur = sched_q.pop_front();
      else cur = '0;
    end
  end

  bit   started = 1'b0;
  vec_t act;
  always @(negedge clk) begin
    if (started) begin
      act = {ram_a, ram_dout, ram_wr, if_enable_out, if_data_out, if_busy_out,
             mem_enable_out, mem_data_out, mem_busy_out};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, act, cur);
      end
    end
  end

  // Results of the most recent directed transaction.
  logic [31:0] wa [0:7];
  logic [7:0]  wd [0:7];
  int          nw;
  int          busy_cnt;
  logic [31:0] first_a;
  logic [31:0] rdata;

  task automatic run(input bit is_mem, input bit rw, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] len, output int done_t);
    if (is_mem) begin
      mem_enable_in = 1'b1; mem_rw_in = rw; mem_addr_in = a; mem_data_in = d; mem_len_in = len;
    end else begin
      if_enable_in = 1'b1; if_addr_in = a;
    end
    nw = 0; busy_cnt = 0; done_t = -1; first_a = '0; rdata = '0;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      if (t == 1) first_a = ram_a;
      if (ram_wr && nw < 8) begin wa[nw] = ram_a; wd[nw] = ram_dout; nw++; end
      if (is_mem ? mem_busy_out : if_busy_out) busy_cnt++;
      if (is_mem ? mem_enable_out : if_enable_out) begin
        done_t = t;
        rdata  = is_mem ? mem_data_out : if_data_out;
        if (is_mem) mem_enable_in = 1'b0; else if_enable_in = 1'b0;
        break;
      end
    end
    if (done_t < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none expected=pulse");
      mem_enable_in = 1'b0; if_enable_in = 1'b0;
    end
    @(negedge clk);
  endtask

  int dt, mem_t, if_t, mem_n, if_n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0100] = 8'h13; mem[16'h0101] = 8'h05; mem[16'h0102] = 8'h00; mem[16'h0103] = 8'h00;
    mem[16'h3000] = 8'h78; mem[16'h3001] = 8'h56; mem[16'h3002] = 8'h34; mem[16'h3003] = 8'h12;

    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("reset_ram_a", ram_a, 32'h0);
    chk("reset_busy", {30'b0, if_busy_out, mem_busy_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 1'b0, 32'h100, 32'h0, 3'd0, dt);
    chk("if_rd_first_addr", first_a, 32'h100);
    chk("if_rd_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("if_rd_done_cycle", 32'(dt), 32'd6);
    chk("if_rd_data", rdata, 32'h00000513);

    run(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd4, dt);
    chk("sw_nwrites", 32'(nw), 32'd4);
    chk("sw_a0", wa[0], 32'h2000);
    chk("sw_d0", {24'b0, wd[0]}, 32'hEF);
    chk("sw_a3", wa[3], 32'h2003);
    chk("sw_d3", {24'b0, wd[3]}, 32'hDE);
    chk("sw_done_cycle", 32'(dt), 32'd5);

    run(1'b1, 1'b1, 32'h2100, 32'h11223344, 3'd1, dt);
    chk("sb_nwrites", 32'(nw), 32'd1);
    chk("sb_d0", {24'b0, wd[0]}, 32'h44);
    chk("sb_done_cycle", 32'(dt), 32'd2);

    run(1'b1, 1'b1, 32'h2200, 32'h11223344, 3'd2, dt);
    chk("sh_nwrites", 32'(nw), 32'd2);
    chk("sh_d1", {24'b0, wd[1]}, 32'h33);
    chk("sh_done_cycle", 32'(dt), 32'd3);

    run(1'b1, 1'b1, 32'h2300, 32'h11223344, 3'd0, dt);
    chk("len0_nwrites", 32'(nw), 32'd0);
    chk("len0_done_cycle", 32'(dt), 32'd1);

    run(1'b1, 1'b1, 32'h2400, 32'hA1B2C3D4, 3'd5, dt);
    chk("len5_nwrites", 32'(nw), 32'd4);
    chk("len5_done_cycle", 32'(dt), 32'd5);

    // Both ports request in the same idle cycle.
    mem_enable_in = 1'b1; mem_rw_in = 1'b0; mem_addr_in = 32'h3000;
    if_enable_in = 1'b1; if_addr_in = 32'h100;
    mem_t = -1; if_t = -1; mem_n = 0; if_n = 0;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      if (t == 1) chk("arb_mem_busy", {31'b0, mem_busy_out}, 32'd1);
      if (mem_enable_out) begin
        mem_n++; mem_t = t; mem_enable_in = 1'b0;
        chk("arb_mem_data", mem_data_out, 32'h12345678);
      end
      if (if_enable_out) begin
        if_n++; if_t = t; if_enable_in = 1'b0;
      end
    end
    chk("arb_mem_done_cycle", 32'(mem_t), 32'd6);
    chk("arb_if_done_cycle", 32'(if_t), 32'd13);
    chk("arb_mem_pulses", 32'(mem_n), 32'd1);
    chk("arb_if_pulses", 32'(if_n), 32'd1);

    // Reset in the third cycle of a read, request kept high.
    if_enable_in = 1'b1; if_addr_in = 32'h100;
    if_t = -1; if_n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 3) rst = 1'b1;
      if (t == 4) begin
        rst = 1'b0;
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_if_busy", {31'b0, if_busy_out}, 32'h0);
      end
      if (if_enable_out) begin
        if_n++;
        if (if_t < 0) begin
          if_t = t;
          chk("rst_reread_data", if_data_out, 32'h00000513);
        end
        if_enable_in = 1'b0;
      end
    end
    chk("rst_done_cycle", 32'(if_t), 32'd10);
    chk("rst_pulses", 32'(if_n), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller serving the instruction-fetch (IF) and MEM-stage request ports over a single byte-wide RAM bus. It accepts one level-held request at a time and gives MEM priority over IF. It serialises each transfer into little-endian byte accesses and returns a one-cycle done pulse with assembled read data. It sits between the pipeline's IF/MEM stages and the external RAM.

## Interface
- No parameters.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_enable_in  in  1  IF read request, held high until done.
- if_addr_in  in  32  IF byte address; reads are always 4 bytes.
- if_enable_out  out  1  IF done pulse, one cycle.
- if_data_out  out  32  IF read word; valid in the done cycle only, 0 otherwise.
- if_busy_out  out  1  IF transaction in progress.
- mem_enable_in  in  1  MEM request, held high until done.
- mem_rw_in  in  1  0 = read, 1 = write.
- mem_addr_in  in  32  MEM byte address.
- mem_data_in  in  32  write data; low bytes are used first.
- mem_len_in  in  3  write length in bytes; ignored for reads, which are always 4 bytes.
- mem_enable_out  out  1  MEM done pulse, one cycle.
- mem_data_out  out  32  MEM read word; valid in the done cycle only, 0 otherwise.
- mem_busy_out  out  1  MEM transaction in progress.
- ram_din  in  8  RAM read byte.
- ram_dout  out  8  RAM write byte.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  1 = write the current byte.

## Operation
- States:
  - IDLE.
  - RD: 4-byte read, byte counter 0..4.
  - WR: len-byte write, byte counter 0..len-1.
  - DONE: one cycle.
- IDLE accepts a request at the clock edge:
  - mem_enable_in has priority over if_enable_in.
  - Address, rw, data and len are latched at accept; later input changes are ignored.
- RD:
  - Presents ram_a = a+k for k = 0..3, one address per cycle.
  - Each byte is captured from ram_din one cycle after its address is presented: byte k goes to word[8k+7:8k].
  - ram_a holds a+3 during the final capture cycle.
  - Then goes to DONE.
- WR:
  - Drives ram_a = a+k, ram_dout = data[8k+7:8k], ram_wr = 1 for k = 0..len-1.
  - Then goes to DONE.
- Write length: len = 1 or 2 writes that many bytes; len = 4 writes 4 bytes. Any other non-zero len writes 4 bytes.
- len = 0 write: no RAM write occurs; goes directly to DONE.
- DONE:
  - Pulses the owner's enable_out for one cycle; read data is on the owner's data_out.
  - Requests are ignored in this cycle.
  - Returns to IDLE, so the earliest next accept is the cycle after DONE.
- Busy flags:
  - if_busy_out is high in RD when the IF port owns the transaction.
  - mem_busy_out is high in RD/WR when the MEM port owns the transaction.
  - Both flags are low in IDLE and DONE.
- Outside RD/WR: ram_a = 0, ram_dout = 0, ram_wr = 0.
- Reset, including mid-transfer:
  - All outputs go to 0 and the state goes to IDLE at the reset edge.
  - No done pulse is issued and the aborted transfer is not resumed.
  - A still-held request is re-accepted on the first non-reset IDLE cycle.

## Timing
- All outputs are registered.
- Request visible in cycle C, accepted at the end of C.
- Read:
  - Addresses a..a+3 in cycles C+1..C+4 (a+3 held in C+5).
  - Bytes captured at the end of C+2..C+5.
  - Done and data in C+6. Latency 6 cycles; busy in C+1..C+5.
- Write of n bytes: ram_wr high in C+1..C+n, done in C+n+1.
- len = 0 write: done in C+1.
- Back-to-back: a request held through DONE (cycle D) is accepted at the end of D+1.
- Arbitration: an IF request arriving during a MEM transaction waits, and vice versa. If both requests are pending in IDLE, MEM wins.

## Test plan
- IF read at 0x100, RAM bytes 0x13,0x05,0x00,0x00:
  - ram_a = 0x100..0x103 in C+1..C+4.
  - if_enable_out = 1 with if_data_out = 0x00000513 in C+6 only.
  - if_busy_out high C+1..C+5.
- MEM SW, addr 0x2000, data 0xDEADBEEF, len 4:
  - ram_wr high C+1..C+4 with (0x2000,0xEF), (0x2001,0xBE), (0x2002,0xAD), (0x2003,0xDE).
  - mem_enable_out in C+5.
- MEM SB and SH, data 0x11223344:
  - len 1 writes only 0x44 and completes in C+2.
  - len 2 writes 0x44,0x33 and completes in C+3.
  - len 0 completes in C+1 with no ram_wr.
- Simultaneous IF and MEM read requests in IDLE:
  - The MEM read is served first (mem_busy_out high).
  - The IF read is accepted the cycle after the MEM DONE.
  - Each port gets exactly one done pulse.
- rst asserted in C+3 of a read:
  - From the next cycle all outputs are 0, with no done pulse.
  - Deasserting rst with the request still held causes a fresh read, completing 6 cycles after re-accept.
